// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM controller and its RAM model.
package ram_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_sp_ar_sw.sv
// Single-port RAM, asynchronous read, synchronous write, shared data bus.
// Drives the bus only while selected, output-enabled and not writing.
module ram_sp_ar_sw
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  inout  wire  [DATA_WIDTH-1:0] data_io,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic                  oe_i
);

  logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Read data appears on the bus combinationally from the addressed word.
  assign data_io = (cs_i && oe_i && !we_i) ? mem_q[address_i] : 'z;

  // Store the bus value at the end of a selected write cycle.
  always_ff @(posedge clk_i) begin
    if (cs_i && we_i) begin
      mem_q[address_i] <= data_io;
    end
  end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Request/response front end for an asynchronous-read single-port RAM.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_* must stay stable while req_valid=1 and
// req_ready=0. A response transfers on a rising edge where rsp_valid and
// rsp_ready are both 1; rsp_valid/rsp_rdata hold until then.
module ram_sp_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output state_e                dbg_state_o
);

  state_e                state_q, state_d;
  logic                  cs_q, we_q, oe_q, drv_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rsp_valid_q;
  logic                  accept;

  assign req_ready   = (state_q == IDLE) && !reset;
  assign accept      = req_valid && req_ready;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign ram_address = addr_q;
  assign ram_cs      = cs_q;
  assign ram_we      = we_q;
  assign ram_oe      = oe_q;
  assign dbg_state_o = state_q;

  // Bus is driven only during WRITE; RESP after READ gives a turnaround cycle.
  assign ram_data = drv_q ? wdata_q : 'z;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_we ? WRITE : READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, glitch-free RAM strobes decoded from next state, request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      drv_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= (state_d == WRITE) || (state_d == READ);
      we_q        <= (state_d == WRITE);
      oe_q        <= (state_d == READ);
      drv_q       <= (state_d == WRITE);
      rsp_valid_q <= (state_d == RESP);
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == READ) begin
        rdata_q <= ram_data;
      end
    end
  end

endmodule

// File: doc/ram_sp_ctrl.md
RAM_SP_CTRL -- requirements
Module: ram_sp_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the RAM data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: width of the RAM address.
REQ-003 SHALL use one clock and a synchronous, active-high reset, as below.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  controller accepts a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  request address.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  read data valid.
REQ-012 rsp_ready  input  1  consumer takes the read data.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 ram_address  output  ADDR_WIDTH  RAM address.
REQ-015 ram_data  inout  DATA_WIDTH  bidirectional RAM data bus.
REQ-016 ram_cs, ram_we, ram_oe  output  1 each  chip select, write enable and output enable.

Function
REQ-017 The FSM SHALL have the states IDLE, WRITE, READ and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-019 On acceptance, the controller SHALL register req_addr, req_wdata and req_we, then go to WRITE if req_we = 1, else READ.
REQ-020 WRITE (one cycle) SHALL drive ram_cs=1, ram_we=1, ram_oe=0 and put the registered wdata on ram_data; the RAM captures at the closing edge; next state IDLE.
REQ-021 READ (one cycle) SHALL drive ram_cs=1, ram_we=0, ram_oe=1 with ram_data released to Z; at the closing edge, ram_data is captured into rsp_rdata; next state RESP.
REQ-022 RESP SHALL drive ram_cs=ram_we=ram_oe=0, bus Z, and rsp_valid=1; it holds rsp_valid and rsp_rdata stable until rsp_ready=1, then goes to IDLE.
REQ-023 RESP SHALL double as the bus turnaround: the controller never drives ram_data in the cycle after the RAM drove it.
REQ-024 ram_cs, ram_we, ram_oe, ram_address and the bus drive-enable SHALL be registered outputs, decoded from the next state; no glitching.
REQ-025 ram_data SHALL be driven by the controller only in WRITE; in every other state it is Z.
REQ-026 Write latency SHALL be: accept at edge N, WRITE in cycle N+1, req_ready high again in cycle N+2; peak rate is 1 write per 2 cycles.
REQ-027 Read latency SHALL be: accept at edge N, READ in cycle N+1, rsp_valid high from cycle N+2.
REQ-028 Requests arriving outside IDLE SHALL stall (req_ready=0) and never be dropped; req_* must hold while req_valid=1 and req_ready=0.
REQ-029 If rsp_ready is already 1 on entry to RESP, RESP SHALL last exactly one cycle.
REQ-030 Address arithmetic SHALL NOT be performed; addresses pass through unchanged, full ADDR_WIDTH range, no wrap logic.

Reset
REQ-031 While reset=1 at a rising edge, the controller SHALL set: state IDLE; ram_cs=ram_we=ram_oe=0; ram_address=0; bus Z; rsp_valid=0; rsp_rdata=0.
REQ-032 Reset asserted mid-operation SHALL abort it: an in-flight write may be lost, and a pending response is discarded.
REQ-033 req_ready SHALL be 0 while reset=1 and 1 in the first cycle after it.

Structure
REQ-034 A shared package ram_ctrl_pkg SHALL hold the state enumeration (IDLE, WRITE, READ, RESP) and the DATA_WIDTH/ADDR_WIDTH defaults.
REQ-035 No sub-module SHALL be used; the tristate driver and FSM are inline; the bench instantiates ram_sp_ar_sw as the downstream RAM.

Verification
REQ-036 Reset, then write 0xA5 @0x10, then read @0x10 with rsp_ready=1 -> rsp_valid one cycle, rsp_rdata=0xA5, 2 cycles after read accept.
REQ-037 Back-to-back writes 0x01@0x00, 0x02@0x01 with req_valid held -> req_ready toggles 1,0,1,0; both locations read back correctly.
REQ-038 Read @0xFF with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata held stable, req_ready=0 throughout; the new request is accepted the cycle after rsp_ready=1.
REQ-039 Read followed immediately by a write of 0x3C @0x20 -> no cycle with both the controller and the RAM driving ram_data (no X on the bus).
REQ-040 Reset asserted during READ -> next cycle: ram_cs=0, rsp_valid=0, bus Z, req_ready=1 after reset is released.
